tap_ir_datapath: RTL and testbench
==================================

# tap_ir_datapath

Instruction-register datapath for the JTAG TAP, sitting directly downstream of the TAP state controller. It consumes the controller's 4-bit state code and performs the IEEE 1149.1 IR actions: capture, shift TDI→TDO, and update. It also decodes the held instruction into one-hot test-mode selects. The block adds no state-machine logic of its own; all sequencing follows the incoming state code.

## Interface
Parameters:
- IR_WIDTH, 4, instruction register length; must be ≥3.
- IDCODE_OP, 4'b0010, opcode loaded on reset and in Test_logic_Reset.
- SAMPLE_OP, 4'b0001, SAMPLE/PRELOAD opcode.
- EXTEST_OP, 4'b0000, EXTEST opcode.
- BYPASS_OP, 4'b1111, BYPASS opcode (all ones).

Ports:
- clk  in  1  TCK.
- TRST  in  1  reset; asynchronous, active-high.
- tap_state  in  4  current controller state, driven straight from the controller state register (not the registered observation outputs).
- TDI  in  1  serial test data in.
- ir_status  in  IR_WIDTH-2  design-specific status, captured into the upper IR bits.
- TDO  out  1  serial data out.
- tdo_en  out  1  high while TDO is valid (Shift_IR).
- ir  out  IR_WIDTH  current instruction.
- sel_extest, sel_sample, sel_idcode, sel_bypass  out  1 each  one-hot instruction decode.

## Operation
- State codes: Test_logic_Reset=0, Run_Test_Idle=1, Select_IR_Scan=2, Capture_IR=3, Shift_IR=4, Exit1_IR=5, Pause_IR=6, Exit2_IR=7, Update_IR=8. Codes 9–15 are treated as Test_logic_Reset.
- Shift register sr[IR_WIDTH-1:0], updated on posedge clk:
  - Capture_IR: sr ← {ir_status, 2'b01}.
  - Shift_IR: sr ← {TDI, sr[IR_WIDTH-1:1]} (LSB first out).
  - All other states: sr holds.
- Instruction register ir, updated on negedge clk:
  - Update_IR: ir ← sr.
  - Test_logic_Reset (or illegal code): ir ← IDCODE_OP.
  - Otherwise: ir holds.
- TDO stage, updated on negedge clk:
  - Shift_IR: TDO ← sr[0], tdo_en ← 1.
  - Otherwise: tdo_en ← 0, TDO holds its last value.
- Decode is combinational from ir and exactly one select is high.
  - EXTEST_OP→sel_extest, SAMPLE_OP→sel_sample, IDCODE_OP→sel_idcode.
  - BYPASS_OP and any unrecognised opcode→sel_bypass.
- TRST (async, dominates both edges): sr←0, ir←IDCODE_OP, TDO←0, tdo_en←0. Selects follow ir, so sel_idcode=1 after reset.

## Timing
- The state code is sampled at the clock edge that leaves the state. The capture value is in sr after the rising edge that exits Capture_IR.
- TDO changes half a cycle after each rising edge; the first Shift_IR falling edge presents capture bit 0 (=1).
- ir changes on the falling edge in Update_IR, half a cycle after entry; selects settle combinationally in the same half cycle.
- Exit1_IR, Pause_IR, Exit2_IR: sr and ir hold indefinitely. Re-entering Shift_IR from Exit2_IR resumes shifting without recapture.
- Capture_IR → Exit1_IR → Update_IR (no shift) loads the captured pattern {ir_status,01} into ir.
- TRST mid-shift: all registers clear immediately. No partial instruction reaches ir.

## Structure
- Shared package tap_pkg: the 4-bit state-code constants (shared with the controller) and the default opcode constants.
- One sub-module, tap_ir_decode: combinational ir → one-hot selects, parameterised by the opcodes.

## Test plan
- Assert/deassert TRST → ir=0010, sel_idcode=1, TDO=0, tdo_en=0, sr=0.
- ir_status=2'b10, Capture_IR then 4× Shift_IR with TDI=0 → TDO sequence 1,0,0,1; tdo_en high only during Shift_IR.
- Shift TDI=1,1,1,1 then Exit1_IR→Update_IR → ir=1111, sel_bypass=1 after the Update_IR falling edge.
- Shift in 4'b0110 (unrecognised), update → ir=0110, sel_bypass=1, other selects 0.
- Shift 2 bits, Exit1→Pause for 5 cycles→Exit2→Shift 2 more bits, update → ir matches the 4 shifted bits; sr unchanged during Pause.
- Load SAMPLE_OP, then pulse TRST in the middle of the next shift → ir=IDCODE_OP immediately and remains so; tap_state=12 → ir=IDCODE_OP at the next falling edge.

Source files
------------

// File: rtl/tap_pkg.sv
// Shared TAP definitions: controller state codes, default opcodes and the
// decoded-select bundle used by the IR datapath.
package tap_pkg;

    // 4-bit state codes exactly as driven by the TAP controller state register
    typedef enum logic [3:0] {
        TAP_TLR       = 4'd0,
        TAP_RTI       = 4'd1,
        TAP_SEL_IR    = 4'd2,
        TAP_CAPTURE_IR = 4'd3,
        TAP_SHIFT_IR  = 4'd4,
        TAP_EXIT1_IR  = 4'd5,
        TAP_PAUSE_IR  = 4'd6,
        TAP_EXIT2_IR  = 4'd7,
        TAP_UPDATE_IR = 4'd8
    } tap_state_e;

    localparam logic [3:0] DEF_EXTEST_OP = 4'b0000;
    localparam logic [3:0] DEF_SAMPLE_OP = 4'b0001;
    localparam logic [3:0] DEF_IDCODE_OP = 4'b0010;
    localparam logic [3:0] DEF_BYPASS_OP = 4'b1111;

    typedef struct packed {
        logic extest;
        logic sample;
        logic idcode;
        logic bypass;
    } ir_sel_t;

    // Codes above Update_IR are not real states; fold them onto Test_logic_Reset
    function automatic tap_state_e norm_state(input logic [3:0] code);
        tap_state_e st;
        if (code > 4'd8) begin
            st = TAP_TLR;
        end else begin
            st = tap_state_e'(code);
        end
        return st;
    endfunction

endpackage

// File: rtl/tap_ir_decode.sv
// Combinational decode of the held instruction into one-hot test-mode selects.
// Anything not explicitly recognised falls through to BYPASS.
module tap_ir_decode
    import tap_pkg::*;
#(
    parameter int                    IR_WIDTH  = 4,
    parameter logic [IR_WIDTH-1:0]   EXTEST_OP = IR_WIDTH'(DEF_EXTEST_OP),
    parameter logic [IR_WIDTH-1:0]   SAMPLE_OP = IR_WIDTH'(DEF_SAMPLE_OP),
    parameter logic [IR_WIDTH-1:0]   IDCODE_OP = IR_WIDTH'(DEF_IDCODE_OP)
) (
    input  logic [IR_WIDTH-1:0] ir,
    output logic                sel_extest,
    output logic                sel_sample,
    output logic                sel_idcode,
    output logic                sel_bypass
);

    ir_sel_t sel;

    always_comb begin
        sel = '0;
        if (ir == EXTEST_OP) begin
            sel.extest = 1'b1;
        end else if (ir == SAMPLE_OP) begin
            sel.sample = 1'b1;
        end else if (ir == IDCODE_OP) begin
            sel.idcode = 1'b1;
        end else begin
            sel.bypass = 1'b1;
        end
    end

    assign sel_extest = sel.extest;
    assign sel_sample = sel.sample;
    assign sel_idcode = sel.idcode;
    assign sel_bypass = sel.bypass;

endmodule

// File: rtl/tap_ir_datapath.sv
// JTAG instruction-register datapath: capture/shift on TCK rising, update and
// TDO launch on TCK falling, all sequenced by the controller's state code.
module tap_ir_datapath
    import tap_pkg::*;
#(
    parameter int                    IR_WIDTH  = 4,
    parameter logic [IR_WIDTH-1:0]   IDCODE_OP = IR_WIDTH'(DEF_IDCODE_OP),
    parameter logic [IR_WIDTH-1:0]   SAMPLE_OP = IR_WIDTH'(DEF_SAMPLE_OP),
    parameter logic [IR_WIDTH-1:0]   EXTEST_OP = IR_WIDTH'(DEF_EXTEST_OP),
    parameter logic [IR_WIDTH-1:0]   BYPASS_OP = '1
) (
    input  logic                clk,
    input  logic                TRST,
    input  logic [3:0]          tap_state,
    input  logic                TDI,
    input  logic [IR_WIDTH-3:0] ir_status,
    output logic                TDO,
    output logic                tdo_en,
    output logic [IR_WIDTH-1:0] ir,
    output logic                sel_extest,
    output logic                sel_sample,
    output logic                sel_idcode,
    output logic                sel_bypass
);

    tap_state_e          state;
    logic [IR_WIDTH-1:0] sr_q, sr_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic                tdo_q, tdo_d;
    logic                tdo_en_q, tdo_en_d;

    assign state = norm_state(tap_state);

    // Rising-edge shift register: the low two capture bits are fixed at 01
    always_comb begin
        sr_d = sr_q;
        unique case (state)
            TAP_CAPTURE_IR: sr_d = {ir_status, 2'b01};
            TAP_SHIFT_IR:   sr_d = {TDI, sr_q[IR_WIDTH-1:1]};
            default:        sr_d = sr_q;
        endcase
    end

    always_comb begin
        ir_d = ir_q;
        unique case (state)
            TAP_UPDATE_IR: ir_d = sr_q;
            TAP_TLR:       ir_d = IDCODE_OP;
            default:       ir_d = ir_q;
        endcase
    end

    // TDO keeps its last bit when not shifting; only the enable drops
    always_comb begin
        tdo_d    = tdo_q;
        tdo_en_d = 1'b0;
        if (state == TAP_SHIFT_IR) begin
            tdo_d    = sr_q[0];
            tdo_en_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge TRST) begin
        if (TRST) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    always_ff @(negedge clk or posedge TRST) begin
        if (TRST) begin
            ir_q     <= IDCODE_OP;
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            ir_q     <= ir_d;
            tdo_q    <= tdo_d;
            tdo_en_q <= tdo_en_d;
        end
    end

    assign ir     = ir_q;
    assign TDO    = tdo_q;
    assign tdo_en = tdo_en_q;

    // BYPASS_OP needs no dedicated compare: it shares the catch-all select
    tap_ir_decode #(
        .IR_WIDTH  (IR_WIDTH),
        .EXTEST_OP (EXTEST_OP),
        .SAMPLE_OP (SAMPLE_OP),
        .IDCODE_OP (IDCODE_OP)
    ) u_decode (
        .ir         (ir_q),
        .sel_extest (sel_extest),
        .sel_sample (sel_sample),
        .sel_idcode (sel_idcode),
        .sel_bypass (sel_bypass)
    );

endmodule

// File: tb/tb_tap_ir_datapath.sv
// Scoreboard bench for tap_ir_datapath: stimulus pushes hand-computed TDO bits
// and post-update instructions; a negedge monitor pops and compares them.
module tb_tap_ir_datapath;

    localparam logic [3:0] S_TLR = 4'd0, S_RTI = 4'd1, S_SEL = 4'd2, S_CAP = 4'd3,
                           S_SHIFT = 4'd4, S_EXIT1 = 4'd5, S_PAUSE = 4'd6,
                           S_EXIT2 = 4'd7, S_UPD = 4'd8;
    // select vector order: {extest, sample, idcode, bypass}
    localparam logic [3:0] SEL_EXT = 4'b1000, SEL_SMP = 4'b0100,
                           SEL_IDC = 4'b0010, SEL_BYP = 4'b0001;

    logic       clk = 1'b0;
    logic       TRST = 1'b1;
    logic [3:0] tap_state = S_TLR;
    logic       TDI = 1'b0;
    logic [1:0] ir_status = 2'b00;
    logic       TDO, tdo_en;
    logic [3:0] ir;
    logic       sel_extest, sel_sample, sel_idcode, sel_bypass;

    typedef struct {
        logic [3:0] ir;
        logic [3:0] sel;
    } ir_exp_t;

    logic    tdo_exp_q[$];
    ir_exp_t ir_exp_q[$];
    int      checks = 0;
    int      fails  = 0;

    tap_ir_datapath dut (
        .clk        (clk),
        .TRST       (TRST),
        .tap_state  (tap_state),
        .TDI        (TDI),
        .ir_status  (ir_status),
        .TDO        (TDO),
        .tdo_en     (tdo_en),
        .ir         (ir),
        .sel_extest (sel_extest),
        .sel_sample (sel_sample),
        .sel_idcode (sel_idcode),
        .sel_bypass (sel_bypass)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0h (t=%0t)", name, act, $time);
        end
    endtask

    function automatic logic [3:0] sel_vec();
        return {sel_extest, sel_sample, sel_idcode, sel_bypass};
    endfunction

    task automatic step(input logic [3:0] s, input logic t = 1'b0);
        @(posedge clk);
        #1;
        tap_state = s;
        TDI       = t;
    endtask

    task automatic shift(input logic t, input logic exp_tdo);
        tdo_exp_q.push_back(exp_tdo);
        step(S_SHIFT, t);
    endtask

    task automatic upd(input logic [3:0] exp_ir, input logic [3:0] exp_sel);
        ir_exp_t e;
        e.ir  = exp_ir;
        e.sel = exp_sel;
        ir_exp_q.push_back(e);
        step(S_UPD);
    endtask

    // Monitor: looks just after each falling edge, where TDO and ir change
    always @(negedge clk) begin
        #1;
        chk("tdo_en", 32'(tdo_en), 32'(tap_state == S_SHIFT && !TRST));
        if (tdo_en) begin
            if (tdo_exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL tdo_unexpected: got TDO=%0b with no expected bit queued", TDO);
            end else begin
                chk("tdo", 32'(TDO), 32'(tdo_exp_q.pop_front()));
            end
        end
        if (!TRST && tap_state >= S_UPD) begin
            if (ir_exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL ir_unexpected: got ir=%0h with no expected value queued", ir);
            end else begin
                ir_exp_t e;
                e = ir_exp_q.pop_front();
                chk("ir", 32'(ir), 32'(e.ir));
                chk("sel", 32'(sel_vec()), 32'(e.sel));
            end
        end
    end

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_ir", 32'(ir), 32'h2);
        chk("rst_sel", 32'(sel_vec()), 32'(SEL_IDC));
        chk("rst_tdo", 32'(TDO), 32'h0);
        chk("rst_tdo_en", 32'(tdo_en), 32'h0);
        @(posedge clk);
        #1;
        TRST = 1'b0;

        // shift straight out of reset: sr must be all zero
        step(S_RTI);
        shift(1'b1, 1'b0); shift(1'b0, 1'b0); shift(1'b1, 1'b0); shift(1'b0, 1'b0);
        step(S_EXIT1);
        upd(4'b0101, SEL_BYP);

        // capture {10,01}, shift zeros: TDO 1,0,0,1 then ir=0000
        ir_status = 2'b10;
        step(S_SEL); step(S_CAP);
        shift(1'b0, 1'b1); shift(1'b0, 1'b0); shift(1'b0, 1'b0); shift(1'b0, 1'b1);
        step(S_EXIT1);
        upd(4'b0000, SEL_EXT);

        // shift in all ones -> BYPASS
        step(S_SEL); step(S_CAP);
        shift(1'b1, 1'b1); shift(1'b1, 1'b0); shift(1'b1, 1'b0); shift(1'b1, 1'b1);
        step(S_EXIT1);
        upd(4'b1111, SEL_BYP);

        // unrecognised opcode 0110 (LSB first: 0,1,1,0) -> BYPASS
        step(S_SEL); step(S_CAP);
        shift(1'b0, 1'b1); shift(1'b1, 1'b0); shift(1'b1, 1'b0); shift(1'b0, 1'b1);
        step(S_EXIT1);
        upd(4'b0110, SEL_BYP);

        // split shift across a pause, capture {01,01}
        ir_status = 2'b01;
        step(S_SEL); step(S_CAP);
        shift(1'b1, 1'b1); shift(1'b0, 1'b0);
        step(S_EXIT1);
        repeat (5) step(S_PAUSE);
        #1;
        chk("pause_tdo_hold", 32'(TDO), 32'h0);
        chk("pause_ir_hold", 32'(ir), 32'h6);
        step(S_EXIT2);
        shift(1'b1, 1'b1); shift(1'b1, 1'b0);
        step(S_EXIT1);
        upd(4'b1101, SEL_BYP);

        // capture-exit1-update with status 00 loads {00,01} = SAMPLE
        ir_status = 2'b00;
        step(S_SEL); step(S_CAP); step(S_EXIT1);
        upd(4'b0001, SEL_SMP);

        // TRST in the middle of a shift
        step(S_SEL); step(S_CAP);
        shift(1'b1, 1'b1); shift(1'b0, 1'b0);
        @(posedge clk);
        #1;
        tap_state = S_SHIFT;
        #1;
        TRST = 1'b1;
        #1;
        chk("trst_ir", 32'(ir), 32'h2);
        chk("trst_sel", 32'(sel_vec()), 32'(SEL_IDC));
        chk("trst_tdo", 32'(TDO), 32'h0);
        chk("trst_tdo_en", 32'(tdo_en), 32'h0);
        @(posedge clk);
        #1;
        tap_state = S_TLR;
        TRST = 1'b0;
        repeat (3) step(S_RTI);
        #1;
        chk("post_trst_ir", 32'(ir), 32'h2);
        chk("post_trst_sel", 32'(sel_vec()), 32'(SEL_IDC));

        // reload SAMPLE, then an illegal state code forces IDCODE
        step(S_SEL); step(S_CAP); step(S_EXIT1);
        upd(4'b0001, SEL_SMP);
        begin
            ir_exp_t e;
            e.ir  = 4'b0010;
            e.sel = SEL_IDC;
            ir_exp_q.push_back(e);
        end
        step(4'd12);
        step(S_RTI);
        step(S_RTI);
        #1;
        chk("illegal_ir_hold", 32'(ir), 32'h2);

        repeat (2) @(posedge clk);
        chk("tdo_queue_drained", 32'(tdo_exp_q.size()), 32'h0);
        chk("ir_queue_drained", 32'(ir_exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
